// File: rtl/risc_alu_issue.sv
// ID/EX issue stage: decodes the ID instruction, selects forwarded operands and
// registers them for the ALU, inserting bubbles for load-use hazards and illegal encodings.
module risc_alu_issue #(
   parameter int XLEN   = 32,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [31:0]     id_instr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic            ex_stall,
   input  logic            ex_flush,
   input  logic [4:0]      exmem_rd,
   input  logic            exmem_reg_wr,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [4:0]      memwb_rd,
   input  logic            memwb_reg_wr,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] operandA,
   output logic [XLEN-1:0] operandB,
   output logic [2:0]      alu_op,
   output logic            ex_valid,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_wr,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic            ex_branch,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_illegal,
   output logic            hazard_stall
);

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] funct3;
   logic       f7b5;

   assign opcode = id_instr[6:0];
   assign rd     = id_instr[11:7];
   assign funct3 = id_instr[14:12];
   assign rs1    = id_instr[19:15];
   assign rs2    = id_instr[24:20];
   assign f7b5   = id_instr[30];

   logic [XLEN-1:0] imm_i, imm_s, shamt_i;
   assign imm_i   = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
   assign imm_s   = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
   assign shamt_i = {{(XLEN-5){1'b0}}, id_instr[24:20]};

   // Youngest in-flight writer wins; x0 is hardwired to zero regardless of source.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] rf_data,
      input logic [4:0]      em_rd,
      input logic            em_wr,
      input logic [XLEN-1:0] em_res,
      input logic [4:0]      mw_rd,
      input logic            mw_wr,
      input logic [XLEN-1:0] mw_res
   );
      if (rs == 5'd0)                           return '0;
      if (FWD_EN && em_wr && (em_rd == rs))     return em_res;
      if (FWD_EN && mw_wr && (mw_rd == rs))     return mw_res;
      return rf_data;
   endfunction

   logic [XLEN-1:0] rs1_val, rs2_val;
   assign rs1_val = fwd_sel(rs1, id_rs1_data, exmem_rd, exmem_reg_wr, exmem_result,
                            memwb_rd, memwb_reg_wr, memwb_result);
   assign rs2_val = fwd_sel(rs2, id_rs2_data, exmem_rd, exmem_reg_wr, exmem_result,
                            memwb_rd, memwb_reg_wr, memwb_result);

   logic            dec_legal, dec_reg_wr, dec_mem_rd, dec_mem_wr, dec_branch, uses_rs2;
   logic [2:0]      dec_op;
   logic [4:0]      dec_rd;
   logic [XLEN-1:0] dec_a, dec_b, dec_store;

   // Instruction decode and operand selection for the supported RV32I subset.
   always_comb begin
      dec_legal  = 1'b0;
      dec_reg_wr = 1'b0;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
      dec_branch = 1'b0;
      uses_rs2   = 1'b0;
      dec_op     = OP_ADD;
      dec_rd     = 5'd0;
      dec_a      = rs1_val;
      dec_b      = '0;
      dec_store  = '0;
      case (opcode)
         OPC_R: begin
            uses_rs2   = 1'b1;
            dec_reg_wr = 1'b1;
            dec_rd     = rd;
            dec_b      = rs2_val;
            dec_legal  = 1'b1;
            case (funct3)
               3'b000:  dec_op = f7b5 ? OP_SUB : OP_ADD;
               3'b111:  begin dec_op = OP_AND; dec_legal = !f7b5; end
               3'b110:  begin dec_op = OP_OR;  dec_legal = !f7b5; end
               3'b001:  begin dec_op = OP_SLL; dec_legal = !f7b5; end
               3'b101:  begin dec_op = OP_SRL; dec_legal = !f7b5; end
               default: dec_legal = 1'b0;
            endcase
            if (dec_op == OP_SLL || dec_op == OP_SRL)
               dec_b = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
         end
         OPC_I: begin
            dec_reg_wr = 1'b1;
            dec_rd     = rd;
            dec_b      = imm_i;
            dec_legal  = 1'b1;
            case (funct3)
               3'b000:  dec_op = OP_ADD;
               3'b111:  dec_op = OP_AND;
               3'b110:  dec_op = OP_OR;
               3'b001:  begin dec_op = OP_SLL; dec_b = shamt_i; end
               3'b101:  begin dec_op = OP_SRL; dec_b = shamt_i; dec_legal = !f7b5; end
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_LW: begin
            dec_legal  = (funct3 == 3'b010);
            dec_reg_wr = 1'b1;
            dec_mem_rd = 1'b1;
            dec_rd     = rd;
            dec_b      = imm_i;
         end
         OPC_SW: begin
            dec_legal  = (funct3 == 3'b010);
            uses_rs2   = 1'b1;
            dec_mem_wr = 1'b1;
            dec_b      = imm_s;
            dec_store  = rs2_val;
         end
         OPC_BEQ: begin
            dec_legal  = (funct3 == 3'b000);
            uses_rs2   = 1'b1;
            dec_branch = 1'b1;
            dec_op     = OP_SUB;
            dec_b      = rs2_val;
         end
         default: dec_legal = 1'b0;
      endcase
      if (rd == 5'd0)
         dec_reg_wr = 1'b0;
   end

   assign hazard_stall = id_valid && ex_valid && ex_mem_rd && (ex_rd != 5'd0) &&
                         ((rs1 == ex_rd) || (uses_rs2 && (rs2 == ex_rd)));

   logic bubble, mark_illegal;
   assign bubble       = ex_flush || hazard_stall || !id_valid || !dec_legal;
   assign mark_illegal = !ex_flush && !hazard_stall && id_valid && !dec_legal;

   // ID/EX pipeline register: flush beats stall, stall freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         operandA      <= '0;
         operandB      <= '0;
         alu_op        <= OP_ADD;
         ex_valid      <= 1'b0;
         ex_rd         <= 5'd0;
         ex_reg_wr     <= 1'b0;
         ex_mem_rd     <= 1'b0;
         ex_mem_wr     <= 1'b0;
         ex_branch     <= 1'b0;
         ex_store_data <= '0;
         ex_illegal    <= 1'b0;
      end else if (ex_flush || !ex_stall) begin
         if (bubble) begin
            operandA      <= '0;
            operandB      <= '0;
            alu_op        <= OP_ADD;
            ex_valid      <= 1'b0;
            ex_rd         <= 5'd0;
            ex_reg_wr     <= 1'b0;
            ex_mem_rd     <= 1'b0;
            ex_mem_wr     <= 1'b0;
            ex_branch     <= 1'b0;
            ex_store_data <= '0;
            ex_illegal    <= mark_illegal;
         end else begin
            operandA      <= dec_a;
            operandB      <= dec_b;
            alu_op        <= dec_op;
            ex_valid      <= 1'b1;
            ex_rd         <= dec_rd;
            ex_reg_wr     <= dec_reg_wr;
            ex_mem_rd     <= dec_mem_rd;
            ex_mem_wr     <= dec_mem_wr;
            ex_branch     <= dec_branch;
            ex_store_data <= dec_store;
            ex_illegal    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_risc_alu_issue.sv
// Directed self-checking bench for risc_alu_issue: reset, decode, forwarding,
// load-use hazard, immediates, flush/stall priority and illegal encodings.
module tb_risc_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_rs1_data, id_rs2_data;
   logic        ex_stall, ex_flush;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_wr, memwb_reg_wr;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] operandA, operandB, ex_store_data;
   logic [2:0]  alu_op;
   logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_illegal, hazard_stall;
   logic [4:0]  ex_rd;
   logic [5:0]  flags;

   int errors = 0;
   int checks = 0;

   assign flags = {ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_illegal};

   always #5 clk = ~clk;

   risc_alu_issue #(.XLEN(32), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .ex_stall(ex_stall), .ex_flush(ex_flush),
      .exmem_rd(exmem_rd), .exmem_reg_wr(exmem_reg_wr), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_wr(memwb_reg_wr), .memwb_result(memwb_result),
      .operandA(operandA), .operandB(operandB), .alu_op(alu_op), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_branch(ex_branch), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal),
      .hazard_stall(hazard_stall)
   );

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid     = 1'b0;
      id_instr     = 32'h0000_0013;
      id_rs1_data  = '0;
      id_rs2_data  = '0;
      ex_stall     = 1'b0;
      ex_flush     = 1'b0;
      exmem_rd     = '0;
      exmem_reg_wr = 1'b0;
      exmem_result = '0;
      memwb_rd     = '0;
      memwb_reg_wr = 1'b0;
      memwb_result = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst         = 1'b1;
      id_valid    = 1'b1;
      id_instr    = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
      id_rs1_data = 32'd10;
      id_rs2_data = 32'd3;
      tick();
      tick();
      checks++;
      if ({flags, alu_op, ex_rd} !== 14'd0 || operandA !== 32'd0 || operandB !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: flags=%b op=%b rd=%0d A=%h B=%h, required all 0",
                  flags, alu_op, ex_rd, operandA, operandB);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (ex_valid !== 1'b1 || alu_op !== 3'b001) begin
         errors++;
         $display("[TB] FAIL reset_release: valid=%b op=%b, required 1/001", ex_valid, alu_op);
      end
   endtask

   task automatic test_sub();
      idle_inputs();
      id_valid    = 1'b1;
      id_instr    = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
      id_rs1_data = 32'd10;
      id_rs2_data = 32'd3;
      tick();
      checks++;
      if (alu_op !== 3'b001 || operandA !== 32'd10 || operandB !== 32'd3 ||
          ex_rd !== 5'd3 || flags !== 6'b110000) begin
         errors++;
         $display("[TB] FAIL sub: op=%b A=%0d B=%0d rd=%0d flags=%b, required 001/10/3/3/110000",
                  alu_op, operandA, operandB, ex_rd, flags);
      end
      id_instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0);
      tick();
      checks++;
      if (flags !== 6'b100000 || alu_op !== 3'b000) begin
         errors++;
         $display("[TB] FAIL rd_zero: flags=%b op=%b, required 100000/000", flags, alu_op);
      end
      id_instr    = enc_r(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd8);
      id_rs2_data = 32'hFFFF_FF23;
      tick();
      checks++;
      if (alu_op !== 3'b100 || operandB !== 32'h0000_0003) begin
         errors++;
         $display("[TB] FAIL sll_mask: op=%b B=%h, required 100/00000003", alu_op, operandB);
      end
   endtask

   task automatic test_forward();
      idle_inputs();
      id_valid     = 1'b1;
      id_instr     = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd5);
      id_rs1_data  = 32'd100;
      id_rs2_data  = 32'd100;
      exmem_rd     = 5'd1; exmem_reg_wr = 1'b1; exmem_result = 32'd7;
      memwb_rd     = 5'd1; memwb_reg_wr = 1'b1; memwb_result = 32'd9;
      tick();
      checks++;
      if (operandA !== 32'd7 || operandB !== 32'd7) begin
         errors++;
         $display("[TB] FAIL fwd_exmem: A=%0d B=%0d, required 7/7", operandA, operandB);
      end
      exmem_reg_wr = 1'b0;
      tick();
      checks++;
      if (operandA !== 32'd9 || operandB !== 32'd9) begin
         errors++;
         $display("[TB] FAIL fwd_memwb: A=%0d B=%0d, required 9/9", operandA, operandB);
      end
      exmem_reg_wr = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
      tick();
      checks++;
      if (operandA !== 32'd100 || operandB !== 32'd100) begin
         errors++;
         $display("[TB] FAIL fwd_tag0: A=%0d B=%0d, required 100/100", operandA, operandB);
      end
      id_instr     = enc_r(7'b0000000, 5'd1, 5'd0, 3'b000, 5'd5);
      id_rs1_data  = 32'd55;
      tick();
      checks++;
      if (operandA !== 32'd0 || operandB !== 32'd100) begin
         errors++;
         $display("[TB] FAIL x0_zero: A=%0d B=%0d, required 0/100", operandA, operandB);
      end
   endtask

   task automatic test_load_use();
      idle_inputs();
      id_valid    = 1'b1;
      id_instr    = enc_i(12'd0, 5'd2, 3'b010, 5'd4, 7'b0000011);
      id_rs1_data = 32'h40;
      tick();
      checks++;
      if (flags !== 6'b111000 || ex_rd !== 5'd4 || operandA !== 32'h40 || operandB !== 32'd0) begin
         errors++;
         $display("[TB] FAIL lw_issue: flags=%b rd=%0d A=%h B=%h, required 111000/4/40/0",
                  flags, ex_rd, operandA, operandB);
      end
      id_instr    = enc_r(7'b0000000, 5'd1, 5'd4, 3'b000, 5'd6);
      id_rs1_data = 32'h11;
      id_rs2_data = 32'h22;
      #1;
      checks++;
      if (hazard_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hazard_high: hazard_stall=%b, required 1", hazard_stall);
      end
      tick();
      checks++;
      if (flags !== 6'b000000 || operandA !== 32'd0 || hazard_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hazard_bubble: flags=%b A=%h hz=%b, required 000000/0/0",
                  flags, operandA, hazard_stall);
      end
      memwb_rd = 5'd4; memwb_reg_wr = 1'b1; memwb_result = 32'h55;
      tick();
      checks++;
      if (flags !== 6'b110000 || ex_rd !== 5'd6 || operandA !== 32'h55 || operandB !== 32'h22) begin
         errors++;
         $display("[TB] FAIL hazard_reissue: flags=%b rd=%0d A=%h B=%h, required 110000/6/55/22",
                  flags, ex_rd, operandA, operandB);
      end
   endtask

   task automatic test_imm_mem();
      idle_inputs();
      id_valid    = 1'b1;
      id_instr    = enc_i(12'h021, 5'd1, 3'b001, 5'd7, 7'b0010011);
      id_rs1_data = 32'd5;
      tick();
      checks++;
      if (alu_op !== 3'b100 || operandA !== 32'd5 || operandB !== 32'd1) begin
         errors++;
         $display("[TB] FAIL slli: op=%b A=%0d B=%0d, required 100/5/1", alu_op, operandA, operandB);
      end
      id_instr    = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
      id_rs1_data = 32'd123;
      tick();
      checks++;
      if (alu_op !== 3'b000 || operandA !== 32'd0 || operandB !== 32'hFFFF_FFFF || ex_rd !== 5'd1) begin
         errors++;
         $display("[TB] FAIL addi_neg: op=%b A=%h B=%h rd=%0d, required 000/0/FFFFFFFF/1",
                  alu_op, operandA, operandB, ex_rd);
      end
      id_instr    = enc_s(12'hFFC, 5'd2, 5'd1);
      id_rs1_data = 32'h1000;
      id_rs2_data = 32'hABCD;
      tick();
      checks++;
      if (flags !== 6'b100100 || operandA !== 32'h1000 || operandB !== 32'hFFFF_FFFC ||
          ex_store_data !== 32'hABCD) begin
         errors++;
         $display("[TB] FAIL sw: flags=%b A=%h B=%h sd=%h, required 100100/1000/FFFFFFFC/ABCD",
                  flags, operandA, operandB, ex_store_data);
      end
      id_instr    = {7'b0, 5'd2, 5'd1, 3'b000, 5'b0, 7'b1100011};
      id_rs1_data = 32'd8;
      id_rs2_data = 32'd8;
      tick();
      checks++;
      if (flags !== 6'b100010 || alu_op !== 3'b001 || operandA !== 32'd8 || operandB !== 32'd8) begin
         errors++;
         $display("[TB] FAIL beq: flags=%b op=%b A=%0d B=%0d, required 100010/001/8/8",
                  flags, alu_op, operandA, operandB);
      end
   endtask

   task automatic test_flush_stall();
      idle_inputs();
      id_valid    = 1'b1;
      id_instr    = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd9);
      id_rs1_data = 32'hF0;
      id_rs2_data = 32'h0F;
      tick();
      ex_stall = 1'b1;
      ex_flush = 1'b1;
      tick();
      checks++;
      if (flags !== 6'b000000 || operandA !== 32'd0 || operandB !== 32'd0) begin
         errors++;
         $display("[TB] FAIL flush_over_stall: flags=%b A=%h B=%h, required 000000/0/0",
                  flags, operandA, operandB);
      end
      ex_stall    = 1'b0;
      ex_flush    = 1'b0;
      id_instr    = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd10);
      id_rs1_data = 32'hFF;
      tick();
      ex_stall    = 1'b1;
      id_instr    = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd11);
      id_rs1_data = 32'h1;
      tick();
      tick();
      checks++;
      if (alu_op !== 3'b010 || ex_rd !== 5'd10 || operandA !== 32'hFF || operandB !== 32'h0F ||
          flags !== 6'b110000) begin
         errors++;
         $display("[TB] FAIL stall_hold: op=%b rd=%0d A=%h B=%h flags=%b, required 010/10/FF/0F/110000",
                  alu_op, ex_rd, operandA, operandB, flags);
      end
      ex_stall = 1'b0;
      id_instr = {25'h0, 7'b1101111};
      tick();
      checks++;
      if (flags !== 6'b000001 || operandA !== 32'd0) begin
         errors++;
         $display("[TB] FAIL illegal: flags=%b A=%h, required 000001/0", flags, operandA);
      end
      id_valid = 1'b0;
      tick();
      checks++;
      if (flags !== 6'b000000) begin
         errors++;
         $display("[TB] FAIL illegal_clear: flags=%b, required 000000", flags);
      end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_forward();
      test_load_use();
      test_imm_mem();
      test_flush_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
